// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared register map and widths for the button debouncer
//
// Purpose: register offsets, CFG width and the effective-period helper used by
// button_debouncer and debounce_cell.
// Ports: none (package).
package button_debouncer_pkg;

  localparam int CFG_W = 16;

  localparam logic [31:0] OFS_STATE = 32'h0;
  localparam logic [31:0] OFS_EDGE  = 32'h4;
  localparam logic [31:0] OFS_CFG   = 32'h8;
  localparam logic [31:0] OFS_RAW   = 32'hC;

  // Register index as decoded from address bits [3:2].
  typedef enum logic [1:0] {
    REG_STATE = OFS_STATE[3:2],
    REG_EDGE  = OFS_EDGE[3:2],
    REG_CFG   = OFS_CFG[3:2],
    REG_RAW   = OFS_RAW[3:2]
  } reg_sel_t;

  // Terminal count for the mismatch counter: max(cfg,1) - 1.
  function automatic logic [CFG_W-1:0] cfg_limit(input logic [CFG_W-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - 1'b1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - per-button synchronizer, mismatch counter and debounced level
//
// Purpose: synchronize one raw pin and flip the debounced level once the
// synchronized value has disagreed with it for limit+1 consecutive clocks.
// Ports:
//   clk, reset : clock, async active-high reset
//   pin        : raw asynchronous button pin
//   limit      : terminal count (effective period - 1)
//   sync       : synchronized pin level
//   level      : debounced level
//   rise       : combinational pulse, high on the edge where level goes 0->1
module debounce_cell
  import button_debouncer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pin,
  input  logic [CFG_W-1:0] limit,
  output logic             sync,
  output logic             level,
  output logic             rise
);

  logic             meta;
  logic [CFG_W-1:0] count;
  logic             mismatch;
  logic             expire;

  assign mismatch = (sync != level);
  // >= rather than == so a period lowered mid-count still fires promptly.
  assign expire   = mismatch && (count >= limit);
  assign rise     = expire && !level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      count <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (expire) begin
        level <= ~level;
        count <= '0;
      end else if (mismatch) begin
        count <= count + 1'b1;
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-button debouncer with press-edge interrupt and bus registers
//
// Purpose: debounce BUTTONCOUNT pins, latch press edges, expose STATE/EDGE/CFG/RAW.
// Ports:
//   clk, reset      : clock, async active-high reset
//   buttons_in      : raw asynchronous button pins
//   address_in      : bus address (bits [3:2] decoded)
//   sel_in          : device select
//   read_in         : read strobe (reads have no side effects)
//   read_value_out  : read data, 0 when not selected
//   write_mask_in   : byte write enables, all-zero means read
//   write_value_in  : write data
//   ready_out       : bus acknowledge (zero wait states)
//   irq_out         : OR of latched press flags
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int BUTTONCOUNT      = 4,
  parameter int DEBOUNCE_DEFAULT = 36000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out,
  output logic                   irq_out
);

  logic [CFG_W-1:0]       cfg;
  logic [CFG_W-1:0]       limit;
  logic [BUTTONCOUNT-1:0] raw;
  logic [BUTTONCOUNT-1:0] state;
  logic [BUTTONCOUNT-1:0] rise;
  logic [BUTTONCOUNT-1:0] edge_flags;
  logic [BUTTONCOUNT-1:0] edge_clr;
  logic [31:0]            rdata;
  reg_sel_t               reg_sel;
  logic                   wr;

  logic unused_bits;
  assign unused_bits = ^{address_in[31:4], address_in[1:0], read_in,
                         write_value_in[31:16], write_mask_in[3:2]};

  assign reg_sel   = reg_sel_t'(address_in[3:2]);
  assign wr        = sel_in && (write_mask_in != 4'b0000);
  assign ready_out = sel_in;
  assign irq_out   = |edge_flags;
  assign limit     = cfg_limit(cfg);

  for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_cell
    debounce_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .pin   (buttons_in[i]),
      .limit (limit),
      .sync  (raw[i]),
      .level (state[i]),
      .rise  (rise[i])
    );
  end

  // Bits 7:0 are gated by mask bit 0, bits 15:8 by mask bit 1.
  always_comb begin
    edge_clr = '0;
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      edge_clr[i] = wr && (reg_sel == REG_EDGE) && write_mask_in[i / 8] && write_value_in[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_flags <= '0;
      cfg        <= CFG_W'(DEBOUNCE_DEFAULT);
    end else begin
      // A new press on the same cycle as its clear keeps the flag set.
      edge_flags <= (edge_flags & ~edge_clr) | rise;
      if (wr && (reg_sel == REG_CFG)) begin
        if (write_mask_in[0]) cfg[7:0]  <= write_value_in[7:0];
        if (write_mask_in[1]) cfg[15:8] <= write_value_in[15:8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATE: rdata[BUTTONCOUNT-1:0] = state;
      REG_EDGE:  rdata[BUTTONCOUNT-1:0] = edge_flags;
      REG_CFG:   rdata[CFG_W-1:0]       = cfg;
      REG_RAW:   rdata[BUTTONCOUNT-1:0] = raw;
      default:   rdata = '0;
    endcase
  end

  assign read_value_out = sel_in ? rdata : 32'h0;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  buttons_in;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic        irq_out;

  int vec_count  = 0;
  int miscompare = 0;

  always #5 clk = ~clk;

  button_debouncer #(.BUTTONCOUNT(4), .DEBOUNCE_DEFAULT(36000)) dut (
    .clk            (clk),
    .reset          (reset),
    .buttons_in     (buttons_in),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .irq_out        (irq_out)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompare++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    address_in     = addr;
    write_value_in = data;
    write_mask_in  = mask;
    sel_in         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    address_in = addr;
    read_in    = 1'b1;
    sel_in     = 1'b1;
    #1;
    data       = read_value_out;
    rdy        = ready_out;
    sel_in     = 1'b0;
    read_in    = 1'b0;
    #1;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_read(addr, d, r);
    check(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        r;

    vecs[0]  = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h4, 32'h0,        4'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'd36000};
    vecs[3]  = '{1'b0, 32'hC, 32'h0,        4'h0, 32'h0};
    vecs[4]  = '{1'b1, 32'h8, 32'h1234,     4'hF, 32'h0};
    vecs[5]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h1234};
    vecs[6]  = '{1'b1, 32'h8, 32'h00AB,     4'h1, 32'h0};
    vecs[7]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h12AB};
    vecs[8]  = '{1'b1, 32'h8, 32'hFFFF5600, 4'h2, 32'h0};
    vecs[9]  = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h56AB};
    vecs[10] = '{1'b1, 32'h8, 32'hFFFFFFFF, 4'hC, 32'h0};
    vecs[11] = '{1'b0, 32'h8, 32'h0,        4'h0, 32'h56AB};
    vecs[12] = '{1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[13] = '{1'b0, 32'h0, 32'h0,        4'h0, 32'h0};

    reset          = 1'b1;
    buttons_in     = 4'h0;
    address_in     = 32'h0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_irq", {31'h0, irq_out}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      end else begin
        bus_read(vecs[i].addr, d, r);
        check($sformatf("table[%0d]", i), d, vecs[i].exp);
        check($sformatf("table_ready[%0d]", i), {31'h0, r}, 32'h1);
      end
    end
    #1;
    check("deselected_rdata", read_value_out, 32'h0);
    check("deselected_ready", {31'h0, ready_out}, 32'h0);

    // Stable press with CFG=4 shows up exactly 6 clocks later.
    bus_write(32'h8, 32'h4, 4'h3);
    buttons_in = 4'b0001;
    tick(2);
    check_reg("raw_after_sync", 32'hC, 32'h1);
    tick(3);
    check_reg("state_at_5", 32'h0, 32'h0);
    tick(1);
    check_reg("state_at_6", 32'h0, 32'h1);
    check_reg("edge_at_6", 32'h4, 32'h1);
    check("irq_at_6", {31'h0, irq_out}, 32'h1);

    // 3-clock glitch on button 1 is rejected.
    buttons_in = 4'b0011;
    tick(3);
    buttons_in = 4'b0001;
    tick(10);
    check_reg("glitch_state", 32'h0, 32'h1);
    check_reg("glitch_edge", 32'h4, 32'h1);

    // W1C with per-bit selection.
    buttons_in = 4'b0011;
    tick(6);
    check_reg("two_state", 32'h0, 32'h3);
    check_reg("two_edge", 32'h4, 32'h3);
    bus_write(32'h4, 32'h1, 4'h1);
    check_reg("w1c_bit0", 32'h4, 32'h2);
    check("w1c_bit0_irq", {31'h0, irq_out}, 32'h1);
    bus_write(32'h4, 32'h2, 4'h1);
    check_reg("w1c_bit1", 32'h4, 32'h0);
    check("w1c_bit1_irq", {31'h0, irq_out}, 32'h0);

    // Release does not set EDGE.
    buttons_in = 4'b0010;
    tick(6);
    check_reg("release_state", 32'h0, 32'h2);
    check_reg("release_edge", 32'h4, 32'h0);

    // Clear and new rise on the same edge: the set wins.
    buttons_in = 4'b0011;
    tick(5);
    bus_write(32'h4, 32'h1, 4'h1);
    check_reg("collide_state", 32'h0, 32'h3);
    check_reg("collide_edge", 32'h4, 32'h1);
    bus_write(32'h4, 32'hF, 4'h1);

    // CFG=0 behaves as 1: 3-clock latency.
    bus_write(32'h8, 32'h0, 4'h3);
    buttons_in = 4'b0010;
    tick(2);
    check_reg("cfg0_at_2", 32'h0, 32'h3);
    tick(1);
    check_reg("cfg0_at_3", 32'h0, 32'h2);
    buttons_in = 4'b0011;
    tick(3);
    check_reg("cfg0_rise", 32'h0, 32'h3);
    check_reg("cfg0_edge", 32'h4, 32'h1);

    // CFG lowered below counter+1 mid-count fires on the next mismatched cycle.
    bus_write(32'h8, 32'd10, 4'h3);
    buttons_in = 4'b0111;
    tick(4);
    bus_write(32'h8, 32'd2, 4'h3);
    check_reg("lower_before", 32'h0, 32'h3);
    tick(1);
    check_reg("lower_after", 32'h0, 32'h7);

    // Async reset mid-count, no clock edge in between.
    bus_write(32'h8, 32'd10, 4'h3);
    buttons_in = 4'b1111;
    tick(5);
    reset = 1'b1;
    #1;
    check("rst_irq", {31'h0, irq_out}, 32'h0);
    check_reg("rst_state", 32'h0, 32'h0);
    check_reg("rst_edge", 32'h4, 32'h0);
    check_reg("rst_raw", 32'hC, 32'h0);
    check_reg("rst_cfg", 32'h8, 32'd36000);
    bus_read(32'h8, d, r);
    check("rst_ready", {31'h0, r}, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // Pins held through reset appear 2+CFGeff clocks after release.
    bus_write(32'h8, 32'h4, 4'h3);
    tick(4);
    check_reg("post_rst_5", 32'h0, 32'h0);
    tick(1);
    check_reg("post_rst_6", 32'h0, 32'hF);
    check_reg("post_rst_edge", 32'h4, 32'hF);
    check("post_rst_irq", {31'h0, irq_out}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
